// File: rtl/holy_irq_gateway.sv
// holy_irq_gateway: per-source interrupt gateway feeding the PLIC pending logic.
// Each raw line is synchronised, optionally glitch-filtered, then run through an
// IDLE / PENDING / IN_SERVICE state machine with claim/complete handshakes,
// one-deep edge queueing and a sticky overflow flag for lost edges.
// Optional feature macro: GATEWAY_FILTER_EN (enables the per-bit glitch filter).
module holy_irq_gateway #(
  parameter int NUM_IRQS      = 5,
  parameter int ID_W          = $clog2(NUM_IRQS + 1),
  parameter int FILTER_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQS-1:0] irq_in,
  input  logic [NUM_IRQS-1:0] edge_mode,
  input  logic                claim_valid,
  input  logic [ID_W-1:0]     claim_id,
  input  logic                complete_valid,
  input  logic [ID_W-1:0]     complete_id,
  input  logic                clear_overflow,
  output logic [NUM_IRQS-1:0] irq_req,
  output logic [NUM_IRQS-1:0] in_service,
  output logic [NUM_IRQS-1:0] overflow
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PENDING    = 2'd1,
    ST_IN_SERVICE = 2'd2
  } state_e;

  logic [NUM_IRQS-1:0] s1_q, s2_q, s3_q;
  logic [NUM_IRQS-1:0] filt;
  logic [NUM_IRQS-1:0] rise;

  // Two-flop synchroniser plus a delayed copy of the (filtered) level for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= irq_in;
      s2_q <= s1_q;
      s3_q <= filt;
    end
  end

  assign rise = filt & ~s3_q;

`ifdef GATEWAY_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

  for (genvar gi = 0; gi < NUM_IRQS; gi++) begin : g_filt
    logic             filt_q;
    logic [CNT_W-1:0] cnt_q;

    // Filtered value follows s2 only after it has differed for FILTER_CYCLES
    // consecutive cycles; any return to the current value restarts the count.
    always_ff @(posedge clk) begin
      if (rst) begin
        filt_q <= 1'b0;
        cnt_q  <= '0;
      end else if (s2_q[gi] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
        filt_q <= s2_q[gi];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign filt[gi] = filt_q;
  end
`else
  assign filt = s2_q;
`endif

  for (genvar gi = 0; gi < NUM_IRQS; gi++) begin : g_src
    state_e state_q, state_d;
    logic   queued_q, queued_d;
    logic   ovf_q, ovf_d;
    logic   claim_hit, complete_hit, erise;

    // IDs are 1-based; ID 0 and out-of-range IDs never match any source.
    assign claim_hit    = claim_valid    && (claim_id    == ID_W'(gi + 1));
    assign complete_hit = complete_valid && (complete_id == ID_W'(gi + 1));
    assign erise        = rise[gi] & edge_mode[gi];

    // Per-source state, queue and sticky overflow registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= ST_IDLE;
        queued_q <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        queued_q <= queued_d;
        ovf_q    <= ovf_d;
      end
    end

    // Next state: handshakes, retraction, edge queueing and overflow (set beats clear).
    always_comb begin
      state_d  = state_q;
      queued_d = queued_q;
      ovf_d    = ovf_q & ~clear_overflow;
      case (state_q)
        ST_IDLE: begin
          if (edge_mode[gi] ? rise[gi] : filt[gi]) state_d = ST_PENDING;
        end
        ST_PENDING: begin
          if (claim_hit)                         state_d = ST_IN_SERVICE;
          else if (!edge_mode[gi] && !filt[gi])  state_d = ST_IDLE;
          if (erise) begin
            if (queued_q) ovf_d    = 1'b1;
            else          queued_d = 1'b1;
          end
        end
        ST_IN_SERVICE: begin
          if (complete_hit) begin
            if (edge_mode[gi]) begin
              // A queued edge re-pends the source; a fresh rise this cycle
              // takes its place in the queue (or re-pends if nothing was queued).
              if (queued_q) begin
                state_d  = ST_PENDING;
                queued_d = erise;
              end else begin
                state_d  = erise ? ST_PENDING : ST_IDLE;
                queued_d = 1'b0;
              end
            end else begin
              state_d  = filt[gi] ? ST_PENDING : ST_IDLE;
              queued_d = 1'b0;
            end
          end else if (erise) begin
            if (queued_q) ovf_d    = 1'b1;
            else          queued_d = 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          queued_d = 1'b0;
        end
      endcase
      if (!edge_mode[gi]) queued_d = 1'b0;
    end

    assign irq_req[gi]    = (state_q == ST_PENDING);
    assign in_service[gi] = (state_q == ST_IN_SERVICE);
    assign overflow[gi]   = ovf_q;
  end

endmodule
